// File: rtl/exu_gpr_file_if.sv
// rtl/exu_gpr_file_if.sv - EXU general-purpose register file port bundle
interface exu_gpr_if_t #(
   parameter int RV_XLEN   = 32,
   parameter int RV_GPR_AW = 5
);
   logic [RV_GPR_AW-1:0] ra1;
   logic [RV_GPR_AW-1:0] ra2;
   logic [RV_XLEN-1:0]   rd1;
   logic [RV_XLEN-1:0]   rd2;
   logic                 wen;
   logic [RV_GPR_AW-1:0] wa;
   logic [RV_XLEN-1:0]   wd;

   // EXU handlers drive addresses and write data
   modport mst (output ra1, ra2, wen, wa, wd, input rd1, rd2);
   // Register file answers with read data
   modport slv (input ra1, ra2, wen, wa, wd, output rd1, rd2);
endinterface

// File: rtl/exu_gpr_file.sv
// rtl/exu_gpr_file.sv - two-read one-write GPR file with post-reset clear sequence
module exu_gpr_file #(
   parameter int RV_XLEN   = 32,
   parameter int RV_GPR_AW = 5
) (
   input  logic           clk,
   input  logic           rst,
   exu_gpr_if_t.slv       gpr_slv,
   output logic           init_busy
);
   localparam int NREG = 2 ** RV_GPR_AW;

   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] READY = 1'b1;

   logic [0:0]           state;
   logic [RV_GPR_AW-1:0] init_cnt;
   logic                 cnt_last;

   // x0 is hardwired to zero, so storage starts at x1
   logic [RV_XLEN-1:0]   regs [NREG-1:1];

   assign cnt_last = (init_cnt == {RV_GPR_AW{1'b1}});

   // Init sequencer: walk init_cnt over x1..x(N-1) once after every reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= CLEAR;
         init_cnt  <= {{(RV_GPR_AW-1){1'b0}}, 1'b1};
         init_busy <= 1'b1;
      end else if (state == CLEAR) begin
         if (cnt_last) begin
            state     <= READY;
            init_busy <= 1'b0;
         end else begin
            init_cnt  <= init_cnt + 1'b1;
         end
      end
   end

   // Storage update: clearing owns the array during CLEAR, writes only in READY; no reset tree
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            if (init_cnt != '0)
               regs[init_cnt] <= '0;
         end else if (gpr_slv.wen && (gpr_slv.wa != '0)) begin
            regs[gpr_slv.wa] <= gpr_slv.wd;
         end
      end
   end

   // Combinational reads without bypass; x0 and the clear window read as zero
   always_comb begin
      gpr_slv.rd1 = '0;
      gpr_slv.rd2 = '0;
      if (!init_busy && (gpr_slv.ra1 != '0))
         gpr_slv.rd1 = regs[gpr_slv.ra1];
      if (!init_busy && (gpr_slv.ra2 != '0))
         gpr_slv.rd2 = regs[gpr_slv.ra2];
   end
endmodule

// File: tb/tb_exu_gpr_file.sv
// tb/tb_exu_gpr_file.sv - self-checking bench for exu_gpr_file
module tb_exu_gpr_file;
   logic clk;
   logic rst;
   logic init_busy;

   int n_cmp;
   int n_bad;

   logic [31:0] model [32];

   exu_gpr_if_t gif ();

   exu_gpr_file dut (
      .clk       (clk),
      .rst       (rst),
      .gpr_slv   (gif.slv),
      .init_busy (init_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      gif.wen = 1'b0;
      gif.wa  = '0;
      gif.wd  = '0;
      gif.ra1 = '0;
      gif.ra2 = '0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   // Counts negedges with init_busy high, starting at the negedge after the rst edge
   task automatic count_busy(input string name, output int cnt);
      cnt = 0;
      while (init_busy === 1'b1 && cnt < 100) begin
         gif.ra1 = 5'($urandom_range(0, 31));
         gif.ra2 = 5'($urandom_range(0, 31));
         #1;
         n_cmp++;
         if (gif.rd1 !== 32'h0 || gif.rd2 !== 32'h0) begin
            n_bad++;
            $display("FAIL %s_clear_read: rd1=%h rd2=%h required 0", name, gif.rd1, gif.rd2);
         end
         cnt++;
         @(negedge clk);
      end
      n_cmp++;
      if (cnt != 31) begin
         n_bad++;
         $display("FAIL %s_busy_len: busy cycles=%0d required 31", name, cnt);
      end
   endtask

   task automatic test_reset();
      int cnt;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (init_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_busy: init_busy=%b required 1", init_busy);
      end
      count_busy("reset", cnt);
      model_clear();
      for (int a = 1; a < 32; a++) begin
         gif.ra1 = 5'(a);
         gif.ra2 = 5'(32 - a);
         #1;
         n_cmp++;
         if (gif.rd1 !== 32'h0 || gif.rd2 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_sweep: addr=%0d rd1=%h rd2=%h required 0", a, gif.rd1, gif.rd2);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_basic();
      gif.ra1 = 5'd5;
      gif.ra2 = 5'd5;
      gif.wen = 1'b1;
      gif.wa  = 5'd5;
      gif.wd  = 32'hDEADBEEF;
      #1;
      n_cmp++;
      if (gif.rd1 !== model[5]) begin
         n_bad++;
         $display("FAIL basic_old: rd1=%h required %h", gif.rd1, model[5]);
      end
      @(negedge clk);
      gif.wen = 1'b0;
      model[5] = 32'hDEADBEEF;
      #1;
      n_cmp++;
      if (gif.rd1 !== 32'hDEADBEEF || gif.rd2 !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL basic_new: rd1=%h rd2=%h required deadbeef", gif.rd1, gif.rd2);
      end
      @(negedge clk);
   endtask

   task automatic test_x0();
      gif.wen = 1'b1;
      gif.wa  = 5'd0;
      gif.wd  = 32'hFFFFFFFF;
      @(negedge clk);
      gif.wen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         gif.ra1 = 5'd0;
         gif.ra2 = 5'd0;
         #1;
         n_cmp++;
         if (gif.rd1 !== 32'h0 || gif.rd2 !== 32'h0) begin
            n_bad++;
            $display("FAIL x0_read: rd1=%h rd2=%h required 0", gif.rd1, gif.rd2);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_rmw();
      logic [31:0] want;
      want = model[3] + 32'd4;
      for (int i = 0; i < 4; i++) begin
         gif.ra1 = 5'd3;
         gif.wen = 1'b1;
         gif.wa  = 5'd3;
         #1;
         gif.wd  = gif.rd1 + 32'd1;
         @(negedge clk);
      end
      gif.wen = 1'b0;
      model[3] = want;
      #1;
      n_cmp++;
      if (gif.rd1 !== want) begin
         n_bad++;
         $display("FAIL rmw_result: rd1=%h required %h", gif.rd1, want);
      end
      @(negedge clk);
   endtask

   task automatic test_busy_block();
      int cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      gif.wen = 1'b1;
      gif.wa  = 5'd7;
      gif.wd  = 32'h12345678;
      count_busy("busyblk", cnt);
      gif.wen = 1'b0;
      model_clear();
      gif.ra1 = 5'd7;
      #1;
      n_cmp++;
      if (gif.rd1 !== 32'h0) begin
         n_bad++;
         $display("FAIL busyblk_x7: rd1=%h required 0", gif.rd1);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_clear();
      int cnt;
      gif.wen = 1'b1;
      gif.wa  = 5'd20;
      gif.wd  = 32'hA5A5A5A5;
      @(negedge clk);
      gif.wen = 1'b0;
      gif.ra1 = 5'd20;
      #1;
      n_cmp++;
      if (gif.rd1 !== 32'hA5A5A5A5) begin
         n_bad++;
         $display("FAIL midclr_pre: rd1=%h required a5a5a5a5", gif.rd1);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      count_busy("midclr", cnt);
      model_clear();
      gif.ra1 = 5'd20;
      #1;
      n_cmp++;
      if (gif.rd1 !== 32'h0) begin
         n_bad++;
         $display("FAIL midclr_x20: rd1=%h required 0", gif.rd1);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         gif.ra1 = 5'($urandom_range(0, 31));
         gif.ra2 = ($urandom_range(0, 3) == 0) ? gif.ra1 : 5'($urandom_range(0, 31));
         gif.wen = 1'($urandom_range(0, 1));
         if (gif.wen) begin
            gif.wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            gif.wd = $urandom;
         end else begin
            gif.wa = 'x;
            gif.wd = 'x;
         end
         #1;
         n_cmp++;
         if (gif.rd1 !== model[gif.ra1] || gif.rd2 !== model[gif.ra2]) begin
            n_bad++;
            $display("FAIL random_read: ra1=%0d rd1=%h required %h ra2=%0d rd2=%h required %h",
                     gif.ra1, gif.rd1, model[gif.ra1], gif.ra2, gif.rd2, model[gif.ra2]);
         end
         if (gif.wen && gif.wa != 5'd0) model[gif.wa] = gif.wd;
         @(negedge clk);
      end
      gif.wen = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      idle_inputs();
      model_clear();
      test_reset();
      test_basic();
      test_x0();
      test_rmw();
      test_random();
      test_busy_block();
      test_reset_mid_clear();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
